stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Sequences multi-byte stack transfers for the 24-bit-address core, e.g. 3-byte return addresses for JSR/RTS and PC+P for BRK/RTI.
- Drives the register file's push/pull strobes.
- Generates stack-page addresses from the current S and serialises or assembles up to 4 bytes.
- Sits between the instruction-sequencing FSM and the regfile/memory bus; while busy, it owns the bus.

Parameters:
- STACK_PAGE, 16'h0001: upper 16 address bits of the stack, so the stack address is {STACK_PAGE, S}.
- MAX_BYTES, 4: maximum transfer length. Fixed at 4; the width of wdata/rdata is 8*MAX_BYTES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = push, 1 = pull.
- nbytes  in  2  transfer length minus 1 (0 = 1 byte, 3 = 4 bytes).
- wdata  in  32  push data; byte 0 = LSB. Sampled when start is accepted.
- S  in  8  current stack pointer from regfile.
- DI  in  8  memory read data; valid the cycle after its address.
- AB  out  24  stack address.
- DO  out  8  memory write data.
- WE  out  1  memory write enable.
- push  out  1  to regfile: S decrements at this edge.
- pull  out  1  to regfile: S increments at this edge.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at completion.
- rdata  out  32  assembled pull data; held until the next accepted start.

Behaviour:
- States: IDLE, PUSH, PULL, CAPT.
- Internal state: 2-bit byte counter cnt, 2-bit last index n, 32-bit shadow of wdata.
- Reset values: IDLE; AB = 0, DO = 0, WE = 0, push = 0, pull = 0, busy = 0, done = 0, rdata = 0, cnt = 0.
- IDLE + start:
  - Latch op, n = nbytes, wdata.
  - Push: cnt = n, go to PUSH.
  - Pull: cnt = 0, clear rdata, go to PULL.
  - busy rises next cycle.
- PUSH (1 byte/cycle, highest byte first, matching the 6502 order PCH before PCL):
  - AB = {STACK_PAGE, S}, DO = shadow byte[cnt], WE = 1, push = 1.
  - If cnt == 0: done = 1 next cycle, go to IDLE. Otherwise cnt = cnt - 1.
  - Total: n+1 cycles.
- PULL (LSB first):
  - AB = {STACK_PAGE, S + 1} (8-bit add, wraps FF -> 00), pull = 1, WE = 0.
  - Data for each address is captured the following cycle into rdata byte[cnt-1], overlapped with the next address.
  - After the address for cnt == n, go to CAPT.
  - CAPT: rdata byte[n] = DI, pull = 0, done = 1 next cycle, go to IDLE.
  - Total: n+2 cycles.
- Outputs are registered-free combinational decodes of state and counter. The S feedback through regfile gives the correct address on every cycle.
- done coincides with busy falling. A new start is accepted in the same cycle done is high.
- start while busy is ignored (no queueing).
- S wrap-around (00 -> FF on push, FF -> 00 on pull) is silent and follows 8-bit arithmetic.
- Reset mid-operation aborts immediately. No partial rdata is retained; S is not restored.
- Upstream must not assert txs while busy. Regfile gives txs priority, which would corrupt the sequence.

Optional Feature:
- Macro: STACK_GUARD_EN.
- When defined, adds outputs `ovf` and `unf`, each sticky and cleared by reset or an accepted start:
  - `ovf` sets if a push cycle occurs with S == 8'h00.
  - `unf` sets if a pull cycle occurs with S == 8'hFF.
- When undefined, neither port nor logic exists; wrap behaviour is unchanged.

Decomposition:
- Shared package/include (alongside the define file): op encodings OP_PUSH/OP_PULL, state encodings, default STACK_PAGE constant.
- No sub-module needed; the byte mux/demux is inline.

Test Plan:
- Push 3 bytes (wdata = 0x00123456, S = 0xFF):
  - Writes 0x12 @0x0001FF, 0x34 @0x0001FE, 0x56 @0x0001FD, with push high 3 cycles.
  - done on cycle 4; final S = 0xFC.
- Pull 3 bytes (S = 0xFC, memory 0x0001FD..FF = 56,34,12):
  - Addresses FD, FE, FF; rdata = 0x00123456.
  - done 5 cycles after start; S = 0xFF.
- Push 1 byte with S = 0x00: writes @0x000100, S wraps to 0xFF. With STACK_GUARD_EN, ovf = 1.
- start asserted every cycle during a 4-byte push: only the first is accepted. done pulses once; back-to-back start in the done cycle is accepted.
- reset asserted in the 2nd cycle of a 4-byte pull: next cycle push = pull = WE = 0, busy = 0, rdata = 0.
- Pull 4 bytes, memory DE AD BE EF at S+1..S+4: rdata = 0xEFBEADDE.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// -----------------------------------------------------------------------------
// stack_seq_pkg
// Shared definitions for the stack transfer sequencer:
//   - OP_PUSH / OP_PULL : encodings of the 'op' request input
//   - state_e           : sequencer state encoding
//   - STACK_PAGE_DEFAULT: upper 16 address bits of the stack page
//   - MAX_BYTES_DEFAULT : longest transfer handled (bytes)
// -----------------------------------------------------------------------------
package stack_seq_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_PULL = 1'b1;

    localparam logic [15:0] STACK_PAGE_DEFAULT = 16'h0001;
    localparam int          MAX_BYTES_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_PULL = 2'd2,
        ST_CAPT = 2'd3
    } state_e;

endpackage

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
// Sequences multi-byte stack transfers (1..4 bytes) for the 24-bit-address
// core: return addresses for JSR/RTS, PC+P for BRK/RTI. While busy it owns the
// memory bus and strobes the register file's S push/pull controls.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   one-cycle request, sampled only when idle
//   op      in   0 = push, 1 = pull
//   nbytes  in   transfer length minus one
//   wdata   in   push data (byte 0 = LSB), captured on accept
//   S       in   current stack pointer from the regfile
//   DI      in   memory read data, valid the cycle after its address
//   AB      out  stack address {STACK_PAGE, S} (push) / {STACK_PAGE, S+1} (pull)
//   DO      out  memory write data
//   WE      out  memory write enable
//   push    out  regfile: S decrements at this edge
//   pull    out  regfile: S increments at this edge
//   busy    out  transfer in progress
//   done    out  one-cycle completion pulse (coincides with busy falling)
//   rdata   out  assembled pull data, held until the next accepted start
//   ovf/unf out  (only with STACK_GUARD_EN) sticky push-at-00 / pull-at-FF
//
// Optional feature macro: STACK_GUARD_EN
// -----------------------------------------------------------------------------
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter logic [15:0] STACK_PAGE = STACK_PAGE_DEFAULT,
    parameter int          MAX_BYTES  = MAX_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [1:0]             nbytes,
    input  logic [8*MAX_BYTES-1:0] wdata,
    input  logic [7:0]             S,
    input  logic [7:0]             DI,
    output logic [23:0]            AB,
    output logic [7:0]             DO,
    output logic                   WE,
    output logic                   push,
    output logic                   pull,
    output logic                   busy,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] rdata
`ifdef STACK_GUARD_EN
    ,
    output logic                   ovf,
    output logic                   unf
`endif
);

    state_e                   state_r;
    logic [1:0]               cnt_r;
    logic [1:0]               n_r;
    logic [8*MAX_BYTES-1:0]   wdata_r;

    // Sequencer state, byte counter, data shadow, read assembly and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            n_r     <= 2'd0;
            wdata_r <= '0;
            rdata   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        n_r     <= nbytes;
                        wdata_r <= wdata;
                        case (op)
                            OP_PUSH: begin
                                // Highest byte goes out first (PCH before PCL).
                                cnt_r   <= nbytes;
                                state_r <= ST_PUSH;
                            end
                            OP_PULL: begin
                                cnt_r   <= 2'd0;
                                rdata   <= '0;
                                state_r <= ST_PULL;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_PUSH: begin
                    if (cnt_r == 2'd0) begin
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_PULL: begin
                    // DI now carries the byte addressed in the previous cycle.
                    if (cnt_r != 2'd0) begin
                        rdata[{cnt_r - 2'd1, 3'b000} +: 8] <= DI;
                    end
                    if (cnt_r == n_r) begin
                        state_r <= ST_CAPT;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_CAPT: begin
                    // Last byte arrives one cycle after the final pull address.
                    rdata[{n_r, 3'b000} +: 8] <= DI;
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus and regfile strobes decoded from state; S feedback tracks the address.
    always_comb begin
        AB   = 24'h000000;
        DO   = 8'h00;
        WE   = 1'b0;
        push = 1'b0;
        pull = 1'b0;
        case (state_r)
            ST_PUSH: begin
                AB   = {STACK_PAGE, S};
                DO   = wdata_r[{cnt_r, 3'b000} +: 8];
                WE   = 1'b1;
                push = 1'b1;
            end
            ST_PULL: begin
                AB   = {STACK_PAGE, S + 8'd1};
                pull = 1'b1;
            end
            default: begin
                // IDLE and CAPT drive nothing onto the bus.
                AB = 24'h000000;
            end
        endcase
    end

    assign busy = (state_r != ST_IDLE);

`ifdef STACK_GUARD_EN
    // Sticky wrap detectors, cleared by reset or any accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push && (S == 8'h00)) begin
                ovf <= 1'b1;
            end
            if (pull && (S == 8'hFF)) begin
                unf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_stack_seq
// Self-checking bench for stack_seq. The environment models the regfile S
// counter and a 256-byte stack page with one-cycle read latency. A reference
// timeline per transaction (derived from transfer length and starting S)
// predicts strobes, addresses, write data, rdata, final S and guard flags.
// -----------------------------------------------------------------------------
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [1:0]  nbytes;
    logic [31:0] wdata;
    logic [7:0]  S;
    logic [7:0]  DI;
    logic [23:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic        push;
    logic        pull;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
`ifdef STACK_GUARD_EN
    logic        ovf;
    logic        unf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Environment controls
    logic       env_init;
    logic       s_set;
    logic [7:0] s_set_val;
    logic [7:0] mem [0:255];

    // Reference model state
    logic [7:0] ref_mem [0:255];
    logic [7:0] exp_s;

    always #5 clk = ~clk;

    stack_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .nbytes (nbytes),
        .wdata  (wdata),
        .S      (S),
        .DI     (DI),
        .AB     (AB),
        .DO     (DO),
        .WE     (WE),
        .push   (push),
        .pull   (pull),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata)
`ifdef STACK_GUARD_EN
        ,
        .ovf    (ovf),
        .unf    (unf)
`endif
    );

    // Regfile S counter and stack-page memory with registered read.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (WE) begin
            mem[AB[7:0]] <= DO;
        end
        DI <= mem[AB[7:0]];
        if (s_set)     S <= s_set_val;
        else if (push) S <= S - 8'd1;
        else if (pull) S <= S + 8'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_s(input logic [7:0] v);
        s_set     = 1'b1;
        s_set_val = v;
        @(posedge clk);
        @(negedge clk);
        s_set = 1'b0;
        exp_s = v;
    endtask

    // One transfer, started at the current negedge. With spam set, start stays
    // high through the done cycle so the caller's next transfer is back-to-back.
    task automatic run_xfer(input logic t_op, input logic [1:0] t_nb,
                            input logic [31:0] t_wd, input bit spam);
        logic [7:0]  s0;
        logic [7:0]  a8;
        logic [4:0]  exp_ctl;
        logic [31:0] exp_rd;
        bit          fin;
        bit          act;
        bit          exp_ovf;
        bit          exp_unf;
        int          n;
        int          k;
        int          idx;
        s0      = exp_s;
        n       = int'(t_nb);
        start   = 1'b1;
        op      = t_op;
        nbytes  = t_nb;
        wdata   = t_wd;
        exp_rd  = 32'h0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        fin     = 1'b0;
        k       = 0;
        while (!fin) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (!spam) begin
                // Inputs after acceptance must not matter.
                start  = 1'b0;
                op     = 1'($urandom);
                nbytes = 2'($urandom);
                wdata  = $urandom;
            end
            act = 1'b0;
            a8  = 8'h00;
            if (t_op == 1'b0) begin
                if (k <= n + 1) begin
                    idx     = k - 1;
                    a8      = s0 - 8'(idx);
                    act     = 1'b1;
                    exp_ctl = 5'b10110;
                    if (a8 == 8'h00) exp_ovf = 1'b1;
                    check_val("push_do", {24'h0, DO}, {24'h0, t_wd[8*(n-idx) +: 8]});
                    ref_mem[a8] = t_wd[8*(n-idx) +: 8];
                end else begin
                    exp_ctl = 5'b01000;
                    fin     = 1'b1;
                end
            end else begin
                if (k <= n + 1) begin
                    a8      = s0 + 8'(k);
                    act     = 1'b1;
                    exp_ctl = 5'b10001;
                    if (a8 == 8'h00) exp_unf = 1'b1;
                    exp_rd[8*(k-1) +: 8] = ref_mem[a8];
                end else if (k == n + 2) begin
                    exp_ctl = 5'b10000;
                end else begin
                    exp_ctl = 5'b01000;
                    fin     = 1'b1;
                end
            end
            check_val(t_op ? "pull_ctl" : "push_ctl", {27'h0, busy, done, WE, push, pull}, {27'h0, exp_ctl});
            if (act) check_val(t_op ? "pull_ab" : "push_ab", {8'h0, AB}, {8'h0, 16'h0001, a8});
        end
        if (t_op == 1'b0) exp_s = s0 - 8'(n + 1);
        else              exp_s = s0 + 8'(n + 1);
        check_val("final_s", {24'h0, S}, {24'h0, exp_s});
        if (t_op == 1'b1) check_val("rdata", rdata, exp_rd);
`ifdef STACK_GUARD_EN
        check_val("ovf", {31'h0, ovf}, {31'h0, exp_ovf});
        check_val("unf", {31'h0, unf}, {31'h0, exp_unf});
`endif
    endtask

    initial begin
        logic [31:0] rw;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        nbytes    = 2'd0;
        wdata     = 32'h0;
        env_init  = 1'b1;
        s_set     = 1'b1;
        s_set_val = 8'hFF;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_s = 8'hFF;
        repeat (3) @(negedge clk);
        env_init = 1'b0;
        s_set    = 1'b0;
        check_val("rst_ctl", {27'h0, busy, done, WE, push, pull}, 32'h0);
        check_val("rst_ab", {8'h0, AB}, 32'h0);
        check_val("rst_do", {24'h0, DO}, 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Push 3 bytes from S=FF, then pull them back.
        run_xfer(1'b0, 2'd2, 32'h00123456, 1'b0);
        check_val("tp_push_s", {24'h0, S}, 32'h000000FC);
        run_xfer(1'b1, 2'd2, 32'h0, 1'b0);
        check_val("tp_pull_rd", rdata, 32'h00123456);

        // Single-byte push at S=00 wraps to FF.
        set_s(8'h00);
        run_xfer(1'b0, 2'd0, 32'h000000A5, 1'b0);
        check_val("tp_wrap_s", {24'h0, S}, 32'h000000FF);

        // start held high through a 4-byte push, then a back-to-back pull.
        set_s(8'h40);
        run_xfer(1'b0, 2'd3, 32'hCAFEF00D, 1'b1);
        run_xfer(1'b1, 2'd3, 32'h0, 1'b0);

        // DE AD BE EF at S+1..S+4.
        set_s(8'h90);
        run_xfer(1'b0, 2'd3, 32'hEFBEADDE, 1'b0);
        run_xfer(1'b1, 2'd3, 32'h0, 1'b0);
        check_val("tp_deadbeef", rdata, 32'hEFBEADDE);

        // Reset in the second cycle of a 4-byte pull.
        start  = 1'b1;
        op     = 1'b1;
        nbytes = 2'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_ctl", {27'h0, busy, done, WE, push, pull}, 32'h0);
        check_val("midrst_rdata", rdata, 32'h0);
        exp_s = exp_s + 8'd2;
        check_val("midrst_s", {24'h0, S}, {24'h0, exp_s});
        reset = 1'b0;
        @(negedge clk);

        // Randomized transfers, including wrap-prone S values.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       set_s(8'h00);
                    1:       set_s(8'hFE);
                    default: set_s(8'($urandom));
                endcase
            end
            rw = $urandom;
            run_xfer(1'($urandom), 2'($urandom), rw, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
